// File: rtl/mseq_pkg.sv
// Shared widths, micro-op type codes, field slices and FSM state codes for the micro-sequencer.
package mseq_pkg;

  localparam int unsigned UPC_WIDTH      = 8;
  localparam int unsigned MINST_WIDTH    = 44;
  localparam int unsigned OPCODE_WIDTH   = 5;
  localparam int unsigned SLOT_SHIFT     = 3;
  localparam int unsigned WDOG_LIMIT     = 64;
  localparam int unsigned WDOG_CNT_WIDTH = 8;

  // Micro-instruction field positions
  localparam int unsigned TYPE_MSB = 43;
  localparam int unsigned TYPE_LSB = 41;
  localparam int unsigned TGT_MSB  = 17;
  localparam int unsigned TGT_LSB  = 10;

  typedef enum logic [2:0] {
    MT_ALU = 3'b000,
    MT_IMM = 3'b001,
    MT_MEM = 3'b010,
    MT_CBR = 3'b011,
    MT_BR  = 3'b100,
    MT_END = 3'b111
  } mtype_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

endpackage

// File: rtl/micro_dispatch_table.sv
// Opcode to start-uPC mapping; each opcode owns 2^SLOT_SHIFT consecutive control-store slots.
module micro_dispatch_table
  import mseq_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [UPC_WIDTH-1:0]    start_upc_c
);

  assign start_upc_c = UPC_WIDTH'(opcode) << SLOT_SHIFT;

endmodule

// File: rtl/micro_sequencer.sv
// Control-store sequencer: expands each macro-instruction into its micro-op stream.
// Optional MSEQ_WATCHDOG_EN aborts macro-instructions that issue WDOG_LIMIT micro-ops without END.
module micro_sequencer
  import mseq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [OPCODE_WIDTH-1:0] instr_opcode_i,
  output logic                    instr_done_o,
  output logic                    rom_en_o,
  output logic [UPC_WIDTH-1:0]    rom_addr_o,
  input  logic [MINST_WIDTH-1:0]  rom_data_i,
  output logic [MINST_WIDTH-1:0]  minstr_o,
  output logic                    minstr_valid_o,
  input  logic                    minstr_ready_i,
  input  logic                    cond_flag_i,
  output logic                    busy_o,
  output logic                    wdog_err_o
);

  logic [1:0]             state_q, state_d;
  logic [UPC_WIDTH-1:0]   upc_q, upc_d;
  logic [UPC_WIDTH-1:0]   start_upc;
  logic [MINST_WIDTH-1:0] minstr_q;
  logic                   fresh_q;
  logic                   done_d;
  logic                   accept, hs, is_end, take_br, wdog_trip;

  micro_dispatch_table u_dispatch (
    .opcode      (instr_opcode_i),
    .start_upc_c (start_upc)
  );

  // ROM data is only valid in the first ISSUE cycle; later cycles replay the captured copy.
  assign minstr_o = fresh_q ? rom_data_i : minstr_q;

  assign accept  = (state_q == ST_IDLE) && instr_valid_i;
  assign hs      = (state_q == ST_ISSUE) && minstr_ready_i;
  assign is_end  = (minstr_o[TYPE_MSB:TYPE_LSB] == MT_END);
  assign take_br = (minstr_o[TYPE_MSB:TYPE_LSB] == MT_BR) ||
                   ((minstr_o[TYPE_MSB:TYPE_LSB] == MT_CBR) && cond_flag_i);

`ifdef MSEQ_WATCHDOG_EN
  logic [WDOG_CNT_WIDTH-1:0] op_cnt_q;

  // Trips on the WDOG_LIMIT-th handshake of the current macro-instruction
  assign wdog_trip = (op_cnt_q == WDOG_CNT_WIDTH'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt_q   <= '0;
      wdog_err_o <= 1'b0;
    end else begin
      if (accept) begin
        op_cnt_q <= '0;
      end else if (hs) begin
        op_cnt_q <= op_cnt_q + WDOG_CNT_WIDTH'(1);
      end
      if (hs && wdog_trip && !is_end) begin
        wdog_err_o <= 1'b1;
      end
    end
  end
`else
  assign wdog_trip  = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  // Next-state and micro-branch resolution
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          upc_d   = start_upc;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (hs) begin
          if (is_end || wdog_trip) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (take_br) begin
            upc_d   = minstr_o[TGT_MSB:TGT_LSB];
            state_d = ST_FETCH;
          end else begin
            upc_d   = upc_q + UPC_WIDTH'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State plus outputs registered from the next-state decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      upc_q          <= '0;
      minstr_q       <= '0;
      fresh_q        <= 1'b0;
      instr_ready_o  <= 1'b1;
      busy_o         <= 1'b0;
      rom_en_o       <= 1'b0;
      rom_addr_o     <= '0;
      minstr_valid_o <= 1'b0;
      instr_done_o   <= 1'b0;
    end else begin
      state_q        <= state_d;
      upc_q          <= upc_d;
      if (fresh_q) begin
        minstr_q <= rom_data_i;
      end
      fresh_q        <= (state_q == ST_FETCH);
      instr_ready_o  <= (state_d == ST_IDLE);
      busy_o         <= (state_d != ST_IDLE);
      rom_en_o       <= (state_d == ST_FETCH);
      rom_addr_o     <= upc_d;
      minstr_valid_o <= (state_d == ST_ISSUE);
      instr_done_o   <= done_d;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus randomized control-store programs.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [4:0]  instr_opcode_i;
  logic        instr_done_o;
  logic        rom_en_o;
  logic [7:0]  rom_addr_o;
  logic [43:0] rom_data_i;
  logic [43:0] minstr_o;
  logic        minstr_valid_o;
  logic        minstr_ready_i;
  logic        cond_flag_i;
  logic        busy_o;
  logic        wdog_err_o;

  int checks   = 0;
  int failures = 0;

  logic [43:0] rom [256];

  micro_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid_i  (instr_valid_i),
    .instr_ready_o  (instr_ready_o),
    .instr_opcode_i (instr_opcode_i),
    .instr_done_o   (instr_done_o),
    .rom_en_o       (rom_en_o),
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .minstr_o       (minstr_o),
    .minstr_valid_o (minstr_valid_o),
    .minstr_ready_i (minstr_ready_i),
    .cond_flag_i    (cond_flag_i),
    .busy_o         (busy_o),
    .wdog_err_o     (wdog_err_o)
  );

  always #5 clk = ~clk;

  // Synchronous control store: data appears the cycle after the enabled read
  always @(posedge clk) begin
    if (rom_en_o) rom_data_i <= rom[rom_addr_o];
  end

  function automatic logic [43:0] mk(input logic [2:0] t, input logic [7:0] tgt);
    logic [43:0] w;
    w = 44'($urandom) ^ (44'($urandom) << 32);
    w[43:41] = t;
    w[17:10] = tgt;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    minstr_ready_i = 1'b0;
    instr_valid_i = 1'b0;
    @(negedge clk);
    chk({tag, "_ready"}, instr_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rom_en"}, rom_en_o, 0);
    chk({tag, "_rom_addr"}, rom_addr_o, 0);
    chk({tag, "_mvalid"}, minstr_valid_o, 0);
    chk({tag, "_minstr"}, minstr_o, 0);
    chk({tag, "_done"}, instr_done_o, 0);
    chk({tag, "_wdog"}, wdog_err_o, 0);
    rst_n = 1'b1;
  endtask

  // Offers one macro-instruction and follows its micro-op stream using the sequencing rules
  task automatic run_macro(input logic [4:0] op, input int max_ops, input int stall,
                           input int cond_sel, output int n_ops, output bit ended);
    logic [7:0]  upc;
    logic [43:0] mi;
    logic [2:0]  t;
    logic        cond;
    int          ns;
    upc   = 8'((int'(op) * 8) % 256);
    n_ops = 0;
    ended = 1'b0;
    chk("idle_ready", instr_ready_o, 1);
    instr_valid_i  = 1'b1;
    instr_opcode_i = op;
    @(negedge clk);
    instr_valid_i  = 1'($urandom);
    instr_opcode_i = 5'($urandom);
    chk("done_pulse_cleared", instr_done_o, 0);
    while (n_ops < max_ops && !ended) begin
      chk("fetch_rom_en", rom_en_o, 1);
      chk("fetch_addr", rom_addr_o, upc);
      chk("fetch_busy", busy_o, 1);
      chk("fetch_no_valid", minstr_valid_o, 0);
      @(negedge clk);
      mi = rom[upc];
      chk("issue_valid", minstr_valid_o, 1);
      chk("issue_minstr", minstr_o, mi);
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < ns; s++) begin
        instr_valid_i = 1'($urandom);
        @(negedge clk);
        chk("stall_valid", minstr_valid_o, 1);
        chk("stall_minstr", minstr_o, mi);
        chk("stall_rom_en", rom_en_o, 0);
      end
      cond = (cond_sel < 0) ? 1'($urandom) : 1'(cond_sel);
      minstr_ready_i = 1'b1;
      cond_flag_i    = cond;
      instr_valid_i  = 1'($urandom);
      @(negedge clk);
      minstr_ready_i = 1'b0;
      cond_flag_i    = 1'($urandom);
      instr_valid_i  = 1'b0;
      n_ops++;
      t = mi[43:41];
      if (t == 3'b111) begin
        chk("end_done", instr_done_o, 1);
        chk("end_ready", instr_ready_o, 1);
        chk("end_busy", busy_o, 0);
        ended = 1'b1;
      end
`ifdef MSEQ_WATCHDOG_EN
      else if (n_ops == 64) begin
        chk("wdog_err", wdog_err_o, 1);
        chk("wdog_done", instr_done_o, 1);
        chk("wdog_ready", instr_ready_o, 1);
        ended = 1'b1;
      end
`endif
      else begin
        chk("op_no_done", instr_done_o, 0);
        if (t == 3'b100 || (t == 3'b011 && cond)) upc = mi[17:10];
        else upc = 8'((int'(upc) + 1) % 256);
      end
    end
  endtask

  initial begin
    int  n;
    bit  e;
    rst_n          = 1'b0;
    instr_valid_i  = 1'b0;
    instr_opcode_i = '0;
    minstr_ready_i = 1'b0;
    cond_flag_i    = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = mk(3'b111, 8'h00);
    @(negedge clk);
    reset_check("reset");
    @(negedge clk);

    // Straight-line ALU then END
    rom[16] = mk(3'b000, 8'h77);
    rom[17] = mk(3'b111, 8'h00);
    run_macro(5'd2, 10, 0, -1, n, e);
    chk("t1_ops", 32'(n), 2);
    chk("t1_ended", 32'(e), 1);

    // Unconditional branch skips uPC 9
    rom[8]    = mk(3'b100, 8'h40);
    rom[9]    = mk(3'b000, 8'h00);
    rom[8'h40] = mk(3'b111, 8'h00);
    run_macro(5'd1, 10, 0, -1, n, e);
    chk("t2_ops", 32'(n), 2);

    // Conditional branch, both directions
    rom[24]    = mk(3'b011, 8'h30);
    rom[25]    = mk(3'b111, 8'h00);
    rom[8'h30] = mk(3'b111, 8'h00);
    run_macro(5'd3, 10, 0, 0, n, e);
    chk("t3_not_taken_ops", 32'(n), 2);
    run_macro(5'd3, 10, 0, 1, n, e);
    chk("t3_taken_ops", 32'(n), 2);

    // Long decoder back-pressure
    rom[32] = mk(3'b010, 8'h12);
    rom[33] = mk(3'b001, 8'h34);
    rom[34] = mk(3'b111, 8'h00);
    run_macro(5'd4, 10, 5, -1, n, e);
    chk("t4_ops", 32'(n), 3);

    // uPC wrap 0xFF -> 0x00
    rom[8'hF8] = mk(3'b100, 8'hFF);
    rom[8'hFF] = mk(3'b000, 8'h00);
    rom[8'h00] = mk(3'b111, 8'h00);
    run_macro(5'd31, 10, 0, -1, n, e);
    chk("t5_wrap_ops", 32'(n), 3);

    // Reset while an op is waiting in ISSUE
    rom[40] = mk(3'b000, 8'h00);
    rom[41] = mk(3'b000, 8'h00);
    rom[42] = mk(3'b111, 8'h00);
    run_macro(5'd5, 1, 0, -1, n, e);
    @(negedge clk);
    chk("t5_mid_issue_valid", minstr_valid_o, 1);
    reset_check("mid_issue_reset");
    @(negedge clk);

    // Self-loop: watchdog aborts it, otherwise it runs until reset
    rom[0] = mk(3'b100, 8'h00);
    run_macro(5'd0, 70, 0, -1, n, e);
`ifdef MSEQ_WATCHDOG_EN
    chk("t6_wdog_ops", 32'(n), 64);
    @(negedge clk);
    chk("t6_wdog_sticky", wdog_err_o, 1);
`else
    chk("t6_loop_ops", 32'(n), 70);
    chk("t6_no_wdog", wdog_err_o, 0);
`endif
    reset_check("t6_reset");
    @(negedge clk);

    // Randomized control-store programs
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 9) < 7) rom[i] = mk(3'($urandom_range(0, 6)), 8'($urandom));
        else rom[i] = mk(3'b111, 8'($urandom));
      end
      run_macro(5'($urandom), 25, -1, -1, n, e);
      if (!e) begin
        reset_check("rand_reset");
        @(negedge clk);
      end
      chk("rand_no_wdog", wdog_err_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
